// File: rtl/mips_core_pkg.sv
// Shared core types: address width, branch outcome and the BTB entry layout
// plus its 2-bit saturating counter helper.
package mips_core_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int BTB_TAG_BITS = 10;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  localparam logic [1:0] BTB_CTR_WEAK_TAKEN   = 2'b10;
  localparam logic [1:0] BTB_CTR_STRONG_TAKEN = 2'b11;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [ADDR_WIDTH-1:0]   target;
    logic [1:0]              counter;
  } btb_entry_t;

  // Jumps pin the counter at strong-taken; branches saturate in both directions.
  function automatic logic [1:0] btb_ctr_next(input logic [1:0] ctr,
                                              input BranchOutcome outcome,
                                              input logic is_jump);
    if (is_jump) return BTB_CTR_STRONG_TAKEN;
    if (outcome == TAKEN) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_target_buffer_flush_walker.sv
// btb_flush_walker: IDLE/WALK FSM that sweeps every set once, one per cycle,
// raising busy and presenting the set to invalidate.
module btb_flush_walker
  import mips_core_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  output logic                    busy,
  output logic                    clr_en,
  output logic [$clog2(SETS)-1:0] clr_idx
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int CNT_W    = (IDX_BITS + 1 > 5) ? IDX_BITS + 1 : 5;
  localparam logic [CNT_W-1:0] LAST_SET = CNT_W'(SETS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WALK = 1'b1;

  logic [0:0]       state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            state_q <= S_WALK;
            cnt_q   <= '0;
          end
        end
        S_WALK: begin
          // Flush requests arriving mid-walk are dropped.
          if (cnt_q == LAST_SET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state_q == S_WALK);
  assign clr_en  = busy;
  assign clr_idx = cnt_q[IDX_BITS-1:0];

endmodule

// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer with same-cycle lookup and
// flush walk. Optional forwarding of a same-cycle update: BRANCH_TARGET_BUFFER_BYPASS_EN.
module branch_target_buffer
  import mips_core_pkg::*;
#(
  parameter int SETS     = 16,
  parameter int TAG_BITS = BTB_TAG_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_lookup_valid,
  input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
  output logic                  o_hit,
  output BranchOutcome          o_pred,
  output logic [ADDR_WIDTH-1:0] o_target,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic [ADDR_WIDTH-1:0] i_upd_target,
  input  BranchOutcome          i_upd_outcome,
  input  logic                  i_upd_is_jump,
  input  logic                  i_flush,
  output logic                  o_busy
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_LO   = 2 + IDX_BITS;

  btb_entry_t          table_q [2][SETS];
  logic [SETS-1:0]     lru_q;
  logic                busy;
  logic                clr_en;
  logic [IDX_BITS-1:0] clr_idx;

  btb_flush_walker #(.SETS(SETS)) u_walker (
    .clk     (clk),
    .rst     (rst),
    .flush   (i_flush),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  assign lk_idx = i_lookup_pc[2 +: IDX_BITS];
  assign lk_tag = i_lookup_pc[TAG_LO +: TAG_BITS];
  assign up_idx = i_upd_pc[2 +: IDX_BITS];
  assign up_tag = i_upd_pc[TAG_LO +: TAG_BITS];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_lookup_pc[1:0], i_lookup_pc[ADDR_WIDTH-1:TAG_LO+TAG_BITS],
                            i_upd_pc[1:0], i_upd_pc[ADDR_WIDTH-1:TAG_LO+TAG_BITS]};

  logic [1:0] lk_match, up_match;
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      lk_match[w] = table_q[w][lk_idx].valid && (table_q[w][lk_idx].tag == lk_tag);
      up_match[w] = table_q[w][up_idx].valid && (table_q[w][up_idx].tag == up_tag);
    end
  end

  logic       up_hit, up_alloc, up_way, up_we;
  logic [1:0] up_ctr;
  always_comb begin
    up_hit   = |up_match;
    up_alloc = !up_hit && ((i_upd_outcome == TAKEN) || i_upd_is_jump);
    up_ctr   = i_upd_is_jump ? BTB_CTR_STRONG_TAKEN : BTB_CTR_WEAK_TAKEN;
    if (up_hit) begin
      up_way = up_match[0] ? 1'b0 : 1'b1;
      up_ctr = btb_ctr_next(table_q[up_way][up_idx].counter, i_upd_outcome, i_upd_is_jump);
    end else if (!table_q[0][up_idx].valid) begin
      up_way = 1'b0;
    end else if (!table_q[1][up_idx].valid) begin
      up_way = 1'b1;
    end else begin
      up_way = lru_q[up_idx];
    end
    up_we = i_upd_valid && !busy && (up_hit || up_alloc);
  end

  // Only valid and LRU are reset; payload fields keep whatever they held.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < SETS; s++)
          table_q[w][s].valid <= 1'b0;
      lru_q <= '0;
    end else if (clr_en) begin
      table_q[0][clr_idx].valid <= 1'b0;
      table_q[1][clr_idx].valid <= 1'b0;
    end else if (up_we) begin
      table_q[up_way][up_idx] <= '{valid: 1'b1, tag: up_tag, target: i_upd_target,
                                   counter: up_ctr};
      lru_q[up_idx]           <= ~up_way;
    end
  end

  always_comb begin
    o_hit    = 1'b0;
    o_pred   = NOT_TAKEN;
    o_target = '0;
    if (i_lookup_valid && !busy) begin
      if (lk_match[0]) begin
        o_hit    = 1'b1;
        o_pred   = table_q[0][lk_idx].counter[1] ? TAKEN : NOT_TAKEN;
        o_target = table_q[0][lk_idx].target;
      end else if (lk_match[1]) begin
        o_hit    = 1'b1;
        o_pred   = table_q[1][lk_idx].counter[1] ? TAKEN : NOT_TAKEN;
        o_target = table_q[1][lk_idx].target;
      end
`ifdef BRANCH_TARGET_BUFFER_BYPASS_EN
      if (up_we && (up_idx == lk_idx) && (up_tag == lk_tag)) begin
        o_hit    = 1'b1;
        o_pred   = up_ctr[1] ? TAKEN : NOT_TAKEN;
        o_target = i_upd_target;
      end
`endif
    end
  end

  assign o_busy = busy;

endmodule
